// File: rtl/vram_arbiter.sv
// Round-robin arbiter sharing one 32-bit VRAM port between CPU, layer 1, layer 2 and sprite readers.
// Optional feature macro: VRAM_ARB_CPU_PRIO_EN (CPU wins outright, video channels round-robin).
module vram_arbiter #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_i,
    input  logic        cpu_write_i,
    input  logic [14:0] cpu_addr_i,
    input  logic [31:0] cpu_wrdata_i,
    input  logic [3:0]  cpu_wrbytesel_i,
    output logic        cpu_ack_o,
    output logic        cpu_rddata_valid_o,
    input  logic        l1_req_i,
    input  logic [14:0] l1_addr_i,
    output logic        l1_ack_o,
    output logic        l1_rddata_valid_o,
    input  logic        l2_req_i,
    input  logic [14:0] l2_addr_i,
    output logic        l2_ack_o,
    output logic        l2_rddata_valid_o,
    input  logic        spr_req_i,
    input  logic [14:0] spr_addr_i,
    output logic        spr_ack_o,
    output logic        spr_rddata_valid_o,
    output logic [31:0] rddata_o,
    output logic        mem_en_o,
    output logic        mem_write_o,
    output logic [14:0] mem_addr_o,
    output logic [31:0] mem_wrdata_o,
    output logic [3:0]  mem_wrbytesel_o,
    input  logic [31:0] mem_rddata_i
);

    localparam int unsigned AW   = 15;
    localparam int unsigned DW   = 32;
    localparam int unsigned BW   = 4;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IW   = 2;

`ifdef VRAM_ARB_CPU_PRIO_EN
    localparam bit CPU_PRIO = 1'b1;
`else
    localparam bit CPU_PRIO = 1'b0;
`endif

    logic [NREQ-1:0] req_c;
    logic [NREQ-1:0] grant_c;
    logic            win_vld_c;
    logic [IW-1:0]   win_idx_c;
    logic [IW-1:0]   cand_c;
    logic            rd_grant_c;
    logic [AW-1:0]   win_addr_c;

    logic [IW-1:0]   last_q, last_d;

    logic            mem_en_q;
    logic            mem_write_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wrdata_q;
    logic [BW-1:0]   mem_wrbytesel_q;

    logic [RD_LATENCY:0]         tag_vld_q;
    logic [RD_LATENCY:0][IW-1:0] tag_idx_q;

    logic [NREQ-1:0] valid_q;
    logic [DW-1:0]   rddata_q;

    assign req_c = {spr_req_i, l2_req_i, l1_req_i, cpu_req_i};

    // Search starts one past the last winner and wraps; optional CPU override
    always_comb begin
        win_vld_c = 1'b0;
        win_idx_c = '0;
        cand_c    = '0;
        grant_c   = '0;
        if (CPU_PRIO && req_c[0]) begin
            win_vld_c = 1'b1;
            win_idx_c = '0;
        end
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_c = IW'(last_q + IW'(k));
            if (!win_vld_c && req_c[cand_c] && !(CPU_PRIO && (cand_c == '0))) begin
                win_vld_c = 1'b1;
                win_idx_c = cand_c;
            end
        end
        if (win_vld_c) begin
            grant_c[win_idx_c] = 1'b1;
        end
    end

    always_comb begin
        win_addr_c = cpu_addr_i;
        case (win_idx_c)
            2'd0:    win_addr_c = cpu_addr_i;
            2'd1:    win_addr_c = l1_addr_i;
            2'd2:    win_addr_c = l2_addr_i;
            default: win_addr_c = spr_addr_i;
        endcase
    end

    assign rd_grant_c = win_vld_c && !((win_idx_c == '0) && cpu_write_i);

    // Under CPU priority only video grants rotate the pointer
    always_comb begin
        last_d = last_q;
        if (win_vld_c && !(CPU_PRIO && (win_idx_c == '0))) begin
            last_d = win_idx_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 2'd3;
        end else begin
            last_q <= last_d;
        end
    end

    // Memory command register; fields hold while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_q        <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_addr_q      <= '0;
            mem_wrdata_q    <= '0;
            mem_wrbytesel_q <= '0;
        end else if (win_vld_c) begin
            mem_en_q   <= 1'b1;
            mem_addr_q <= win_addr_c;
            if (win_idx_c == '0) begin
                mem_write_q     <= cpu_write_i;
                mem_wrdata_q    <= cpu_wrdata_i;
                mem_wrbytesel_q <= cpu_write_i ? cpu_wrbytesel_i : 4'hF;
            end else begin
                mem_write_q     <= 1'b0;
                mem_wrbytesel_q <= 4'hF;
            end
        end else begin
            mem_en_q <= 1'b0;
        end
    end

    // Read tags travel alongside the memory pipeline; stage RD_LATENCY meets mem_rddata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
            tag_idx_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[RD_LATENCY-1:0], rd_grant_c};
            tag_idx_q <= {tag_idx_q[RD_LATENCY-1:0], win_idx_c};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            rddata_q <= '0;
        end else begin
            valid_q <= '0;
            if (tag_vld_q[RD_LATENCY]) begin
                valid_q  <= NREQ'(1) << tag_idx_q[RD_LATENCY];
                rddata_q <= mem_rddata_i;
            end
        end
    end

    assign cpu_ack_o          = grant_c[0];
    assign l1_ack_o           = grant_c[1];
    assign l2_ack_o           = grant_c[2];
    assign spr_ack_o          = grant_c[3];
    assign cpu_rddata_valid_o = valid_q[0];
    assign l1_rddata_valid_o  = valid_q[1];
    assign l2_rddata_valid_o  = valid_q[2];
    assign spr_rddata_valid_o = valid_q[3];
    assign rddata_o           = rddata_q;
    assign mem_en_o           = mem_en_q;
    assign mem_write_o        = mem_write_q;
    assign mem_addr_o         = mem_addr_q;
    assign mem_wrdata_o       = mem_wrdata_q;
    assign mem_wrbytesel_o    = mem_wrbytesel_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic against a queue-based reference.
module tb_vram_arbiter;

    localparam int unsigned RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [14:0] addr [4];
    logic        cwr = 1'b0;
    logic [31:0] cwd = '0;
    logic [3:0]  cbs = '0;

    logic        cpu_ack, l1_ack, l2_ack, spr_ack;
    logic        cpu_v, l1_v, l2_v, spr_v;
    logic [31:0] rddata, mem_wrdata, mem_rddata;
    logic        mem_en, mem_write;
    logic [14:0] mem_addr;
    logic [3:0]  mem_bsel;

    logic [31:0] vmem [32768];
    logic [14:0] hist [3];

    always #5 clk = ~clk;

    vram_arbiter #(.RD_LATENCY(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(req[0]), .cpu_write_i(cwr), .cpu_addr_i(addr[0]),
        .cpu_wrdata_i(cwd), .cpu_wrbytesel_i(cbs),
        .cpu_ack_o(cpu_ack), .cpu_rddata_valid_o(cpu_v),
        .l1_req_i(req[1]), .l1_addr_i(addr[1]), .l1_ack_o(l1_ack), .l1_rddata_valid_o(l1_v),
        .l2_req_i(req[2]), .l2_addr_i(addr[2]), .l2_ack_o(l2_ack), .l2_rddata_valid_o(l2_v),
        .spr_req_i(req[3]), .spr_addr_i(addr[3]), .spr_ack_o(spr_ack), .spr_rddata_valid_o(spr_v),
        .rddata_o(rddata), .mem_en_o(mem_en), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_wrdata_o(mem_wrdata), .mem_wrbytesel_o(mem_bsel), .mem_rddata_i(mem_rddata)
    );

    // Memory model: data for the address presented RD_LAT cycles earlier
    always @(posedge clk) begin
        hist[0] <= mem_addr;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
    end
    assign mem_rddata = vmem[hist[RD_LAT-1]];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    typedef struct {
        int          due;
        int          idx;
        logic [14:0] a;
    } rd_t;
    rd_t q[$];

    int          m_last;
    logic        m_en, m_write;
    logic [14:0] m_addr;
    logic [31:0] m_wrdata, m_rddata;
    logic [3:0]  m_bsel;
    bit          hold [4];
    bit          rnd_mode = 1'b0;

    function automatic int pick(input logic [3:0] r, input int last);
`ifdef VRAM_ARB_CPU_PRIO_EN
        if (r[0]) return 0;
        for (int k = 1; k <= 4; k++) begin
            int j = (last + k) % 4;
            if (j != 0 && r[j]) return j;
        end
`else
        for (int k = 1; k <= 4; k++) begin
            int j = (last + k) % 4;
            if (r[j]) return j;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 3; m_en = 0; m_write = 0; m_addr = '0;
        m_wrdata = '0; m_bsel = '0; m_rddata = '0;
        q.delete();
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        #2;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wrdata", mem_wrdata, 32'd0);
        check("rst_mem_bsel", 32'(mem_bsel), 32'd0);
        check("rst_rddata", rddata, 32'd0);
        check("rst_valid", 32'({spr_v, l2_v, l1_v, cpu_v}), 32'd0);
        check("rst_ack", 32'({spr_ack, l2_ack, l1_ack, cpu_ack}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic new_cmd(input int i);
        addr[i] = 15'($urandom);
        if (i == 0) begin
            cwr = 1'($urandom);
            cwd = $urandom;
            cbs = 4'($urandom);
        end
    endtask

    // One clock: check at negedge, advance model, then update stimulus after the edge
    task automatic step();
        int w;
        logic [3:0] ev;
        bit is_wr;
        @(negedge clk);
        w = pick(req, m_last);
        check("ack", 32'({spr_ack, l2_ack, l1_ack, cpu_ack}), (w < 0) ? 32'd0 : (32'd1 << w));
        check("mem_en", 32'(mem_en), 32'(m_en));
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("mem_write", 32'(mem_write), 32'(m_write));
        check("mem_bsel", 32'(mem_bsel), 32'(m_bsel));
        if (m_en && m_write) check("mem_wrdata", mem_wrdata, m_wrdata);
        ev = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = 4'(1 << q[0].idx);
            m_rddata = vmem[q[0].a];
            void'(q.pop_front());
        end
        check("valid", 32'({spr_v, l2_v, l1_v, cpu_v}), 32'(ev));
        check("rddata", rddata, m_rddata);
        if (w >= 0) begin
            is_wr = (w == 0) && cwr;
            m_en = 1; m_addr = addr[w];
            m_write = is_wr;
            m_bsel = is_wr ? cbs : 4'hF;
            if (w == 0) m_wrdata = cwd;
`ifdef VRAM_ARB_CPU_PRIO_EN
            if (w != 0) m_last = w;
`else
            m_last = w;
`endif
            if (!is_wr) q.push_back('{due: cyc + 2 + int'(RD_LAT), idx: w, a: addr[w]});
        end else begin
            m_en = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rnd_mode) begin
                if (w == i) begin
                    req[i] = ($urandom % 3) != 0;
                    new_cmd(i);
                end else if (req[i]) begin
                    if ($urandom % 16 == 0) req[i] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    req[i] = 1'b1;
                    new_cmd(i);
                end
            end else if (w == i && !hold[i]) begin
                req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) vmem[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            addr[i] = '0;
            hold[i] = 1'b0;
        end
        model_reset();
        #1;
        do_reset();

        // Single layer 1 read
        vmem[15'h0123] = 32'hDEADBEEF;
        addr[1] = 15'h0123;
        req[1] = 1'b1;
        repeat (6) step();

        // All four requesting continuously
        do_reset();
        for (int i = 0; i < 4; i++) begin
            hold[i] = 1'b1;
            addr[i] = 15'(16 + i);
        end
        cwr = 1'b0;
        req = 4'hF;
        repeat (8) step();
        req = '0;
        for (int i = 0; i < 4; i++) hold[i] = 1'b0;
        repeat (5) step();

        // CPU write at top of address space
        cwr = 1'b1; addr[0] = 15'h7FFF; cwd = 32'h11223344; cbs = 4'b0101;
        req[0] = 1'b1;
        repeat (5) step();

        // Layer 2 withdraws while CPU wins
        do_reset();
        cwr = 1'b0; addr[0] = 15'h0040; addr[2] = 15'h0200;
        req[0] = 1'b1; req[2] = 1'b1;
        step();
        req[2] = 1'b0;
        repeat (5) step();

        // Reset one cycle after a sprite read grant
        do_reset();
        addr[3] = 15'h1234;
        req[3] = 1'b1;
        step();
        do_reset();
        repeat (6) step();

        // CPU and sprite both requesting continuously
        do_reset();
        cwr = 1'b0; addr[0] = 15'h0001; addr[3] = 15'h0003;
        hold[0] = 1'b1; hold[3] = 1'b1;
        req = 4'b1001;
        repeat (8) step();
        req = '0;
        hold[0] = 1'b0; hold[3] = 1'b0;
        repeat (5) step();

        // Random traffic
        do_reset();
        rnd_mode = 1'b1;
        repeat (3000) step();
        rnd_mode = 1'b0;
        req = '0;
        repeat (6) step();
        check("drain", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
